// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core/memory interface and the memory port arbiter.
// CorePack carries the core-wide bus widths and word types.
// MemArbPack carries the arbiter FSM state and request-owner encodings.

package CorePack;

  localparam int CORE_ADDR_W = 64;
  localparam int CORE_DATA_W = 64;
  localparam int CORE_MASK_W = CORE_DATA_W / 8;

  typedef logic [CORE_ADDR_W-1:0] addr_t;
  typedef logic [CORE_DATA_W-1:0] data_t;
  typedef logic [CORE_MASK_W-1:0] mask_t;

endpackage

package MemArbPack;

  import CorePack::*;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } arb_state_e;

  // OWN_I encodes as 0 so that a cleared owner register reads as fetch.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Requester that should win a tie, given who was served last.
  function automatic owner_e rr_next(input owner_e last);
    return (last == OWN_D) ? OWN_I : OWN_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin grant.
// Ports: i_valid/d_valid request lines, last_owner (requester served last),
//        grant_i/grant_d one-hot (or zero) grant outputs.

module rr_pick2
  import MemArbPack::*;
(
  input  logic   i_valid,
  input  logic   d_valid,
  input  owner_e last_owner,
  output logic   grant_i,
  output logic   grant_d
);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_valid && d_valid) begin
      // Tie: the requester that was not served last wins.
      if (rr_next(last_owner) == OWN_I) begin
        grant_i = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else begin
      grant_i = i_valid;
      grant_d = d_valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream read/write memory port between the
// instruction-fetch (read-only) and data (read/write) requesters.
// Ports: i_req_* / i_rsp_* fetch side, d_req_* / d_rsp_* data side,
//        m_r_* downstream read channel, m_w_* downstream write channel.
// One transaction in flight; zero-wait memory gives 3 cycles accept-to-response.

module mem_port_arbiter
  import CorePack::*;
  import MemArbPack::*;
#(
  parameter int ADDR_W = CORE_ADDR_W,
  parameter int DATA_W = CORE_DATA_W,
  parameter int MASK_W = CORE_MASK_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,

  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [MASK_W-1:0] d_req_wmask,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,

  output logic              m_r_req_valid,
  input  logic              m_r_req_ready,
  output logic [ADDR_W-1:0] m_r_req_addr,
  input  logic              m_r_rsp_valid,
  output logic              m_r_rsp_ready,
  input  logic [DATA_W-1:0] m_r_rsp_data,

  output logic              m_w_req_valid,
  input  logic              m_w_req_ready,
  output logic [ADDR_W-1:0] m_w_req_addr,
  output logic [DATA_W-1:0] m_w_req_data,
  output logic [MASK_W-1:0] m_w_req_mask,
  input  logic              m_w_rsp_valid,
  output logic              m_w_rsp_ready
);

  arb_state_e        state;
  owner_e            last_owner;
  owner_e            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic grant_i;
  logic grant_d;
  logic i_accept;
  logic d_accept;

  rr_pick2 u_pick (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .last_owner (last_owner),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Readiness is offered only while idle; every other state holds off both
  // requesters until the current reply has been delivered.
  assign i_req_ready = (state == IDLE) && grant_i;
  assign d_req_ready = (state == IDLE) && grant_d;
  assign i_accept    = i_req_valid && i_req_ready;
  assign d_accept    = d_req_valid && d_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_D;
      owner_q    <= OWN_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_accept) begin
            owner_q    <= OWN_I;
            last_owner <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= i_req_addr;
            wdata_q    <= '0;
            wmask_q    <= '0;
            state      <= RD_REQ;
          end else if (d_accept) begin
            owner_q    <= OWN_D;
            last_owner <= OWN_D;
            we_q       <= d_req_we;
            addr_q     <= d_req_addr;
            wdata_q    <= d_req_wdata;
            wmask_q    <= d_req_wmask;
            state      <= d_req_we ? WR_REQ : RD_REQ;
          end
        end
        RD_REQ: begin
          if (m_r_req_ready) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (m_r_rsp_valid) begin
            rsp_data_q <= m_r_rsp_data;
            state      <= RESP;
          end
        end
        WR_REQ: begin
          if (m_w_req_ready) begin
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (m_w_rsp_valid) begin
            rsp_data_q <= '0;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Downstream strobes decode the state register and all payload comes from
  // the latched request, so nothing on the m_* side depends on requester
  // inputs. The opcode qualifier keeps each channel tied to the latched
  // request type.
  assign m_r_req_valid = (state == RD_REQ) && !we_q;
  assign m_r_req_addr  = addr_q;
  assign m_r_rsp_ready = (state == RD_WAIT);

  assign m_w_req_valid = (state == WR_REQ) && we_q;
  assign m_w_req_addr  = addr_q;
  assign m_w_req_data  = wdata_q;
  assign m_w_req_mask  = wmask_q;
  assign m_w_rsp_ready = (state == WR_WAIT);

  assign i_rsp_valid = (state == RESP) && (owner_q == OWN_I);
  assign d_rsp_valid = (state == RESP) && (owner_q == OWN_D);
  assign i_rsp_data  = rsp_data_q;
  assign d_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the downstream memory is driven step
// by step from the stimulus sequence, and outputs are sampled mid-cycle.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [63:0] i_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [63:0] i_rsp_data;
  logic        d_req_valid;
  logic        d_req_we;
  logic [63:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic [7:0]  d_req_wmask;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_data;
  logic        m_r_req_valid;
  logic        m_r_req_ready;
  logic [63:0] m_r_req_addr;
  logic        m_r_rsp_valid;
  logic        m_r_rsp_ready;
  logic [63:0] m_r_rsp_data;
  logic        m_w_req_valid;
  logic        m_w_req_ready;
  logic [63:0] m_w_req_addr;
  logic [63:0] m_w_req_data;
  logic [7:0]  m_w_req_mask;
  logic        m_w_rsp_valid;
  logic        m_w_rsp_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_req_addr    (i_req_addr),
    .i_req_ready   (i_req_ready),
    .i_rsp_valid   (i_rsp_valid),
    .i_rsp_data    (i_rsp_data),
    .d_req_valid   (d_req_valid),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_wmask   (d_req_wmask),
    .d_req_ready   (d_req_ready),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_data    (d_rsp_data),
    .m_r_req_valid (m_r_req_valid),
    .m_r_req_ready (m_r_req_ready),
    .m_r_req_addr  (m_r_req_addr),
    .m_r_rsp_valid (m_r_rsp_valid),
    .m_r_rsp_ready (m_r_rsp_ready),
    .m_r_rsp_data  (m_r_rsp_data),
    .m_w_req_valid (m_w_req_valid),
    .m_w_req_ready (m_w_req_ready),
    .m_w_req_addr  (m_w_req_addr),
    .m_w_req_data  (m_w_req_data),
    .m_w_req_mask  (m_w_req_mask),
    .m_w_rsp_valid (m_w_rsp_valid),
    .m_w_rsp_ready (m_w_rsp_ready)
  );

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_wmask = '0;
    m_r_req_ready = 1'b0; m_r_rsp_valid = 1'b0; m_r_rsp_data = '0;
    m_w_req_ready = 1'b0; m_w_rsp_valid = 1'b0;
    repeat (3) step();

    // ---- reset state
    settle();
    chk("rst_m_r_req_valid", 64'(m_r_req_valid), 64'd0);
    chk("rst_m_w_req_valid", 64'(m_w_req_valid), 64'd0);
    chk("rst_m_r_rsp_ready", 64'(m_r_rsp_ready), 64'd0);
    chk("rst_m_w_rsp_ready", 64'(m_w_rsp_ready), 64'd0);
    chk("rst_i_rsp_valid",   64'(i_rsp_valid),   64'd0);
    chk("rst_d_rsp_valid",   64'(d_rsp_valid),   64'd0);
    chk("rst_i_req_ready",   64'(i_req_ready),   64'd0);
    chk("rst_m_r_req_addr",  m_r_req_addr,       64'd0);
    rst = 1'b0;

    // ---- lone fetch, zero-wait memory
    i_req_valid = 1'b1; i_req_addr = 64'h1000; m_r_req_ready = 1'b1;
    settle();
    chk("fetch_c0_i_req_ready", 64'(i_req_ready), 64'd1);
    step();                                   // cycle 1: RD_REQ
    i_req_valid = 1'b0;
    settle();
    chk("fetch_c1_m_r_req_valid", 64'(m_r_req_valid), 64'd1);
    chk("fetch_c1_m_r_req_addr",  m_r_req_addr,       64'h1000);
    chk("fetch_c1_i_rsp_valid",   64'(i_rsp_valid),   64'd0);
    step();                                   // cycle 2: RD_WAIT
    m_r_rsp_valid = 1'b1; m_r_rsp_data = 64'hDEADBEEF_00000013;
    settle();
    chk("fetch_c2_m_r_rsp_ready", 64'(m_r_rsp_ready), 64'd1);
    chk("fetch_c2_m_r_req_valid", 64'(m_r_req_valid), 64'd0);
    step();                                   // cycle 3: RESP
    m_r_rsp_valid = 1'b0;
    settle();
    chk("fetch_c3_i_rsp_valid", 64'(i_rsp_valid), 64'd1);
    chk("fetch_c3_i_rsp_data",  i_rsp_data,       64'hDEADBEEF_00000013);
    chk("fetch_c3_d_rsp_valid", 64'(d_rsp_valid), 64'd0);
    step();
    settle();
    chk("fetch_c4_i_rsp_valid", 64'(i_rsp_valid), 64'd0);

    // ---- data write
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h2008;
    d_req_wdata = 64'h55; d_req_wmask = 8'h01; m_w_req_ready = 1'b1;
    settle();
    chk("wr_d_req_ready", 64'(d_req_ready), 64'd1);
    step();                                   // WR_REQ
    d_req_valid = 1'b0; d_req_wdata = 64'hFFFF; d_req_addr = 64'hBAD0;
    settle();
    chk("wr_m_w_req_valid", 64'(m_w_req_valid), 64'd1);
    chk("wr_m_w_req_addr",  m_w_req_addr,       64'h2008);
    chk("wr_m_w_req_data",  m_w_req_data,       64'h55);
    chk("wr_m_w_req_mask",  64'(m_w_req_mask),  64'h01);
    chk("wr_req_no_read",   64'(m_r_req_valid), 64'd0);
    step();                                   // WR_WAIT
    m_w_req_ready = 1'b0; m_w_rsp_valid = 1'b1;
    settle();
    chk("wr_m_w_rsp_ready", 64'(m_w_rsp_ready), 64'd1);
    chk("wr_wait_no_read",  64'(m_r_req_valid), 64'd0);
    step();                                   // RESP
    m_w_rsp_valid = 1'b0;
    settle();
    chk("wr_d_rsp_valid", 64'(d_rsp_valid), 64'd1);
    chk("wr_d_rsp_data",  d_rsp_data,       64'd0);
    chk("wr_i_rsp_valid", 64'(i_rsp_valid), 64'd0);
    step();
    d_req_we = 1'b0;

    // ---- contention from a fresh reset (last_owner = D)
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 64'h100;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h200;
    m_r_req_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic exp_i;
      exp_i = (n % 2 == 0);
      settle();
      chk($sformatf("cont%0d_i_req_ready", n), 64'(i_req_ready), 64'(exp_i));
      chk($sformatf("cont%0d_d_req_ready", n), 64'(d_req_ready), 64'(!exp_i));
      step();                                 // RD_REQ
      settle();
      chk($sformatf("cont%0d_m_r_req_addr", n), m_r_req_addr, exp_i ? 64'h100 : 64'h200);
      step();                                 // RD_WAIT
      m_r_rsp_valid = 1'b1; m_r_rsp_data = 64'hC0DE_0000_0000_0000 | 64'(n);
      step();                                 // RESP
      m_r_rsp_valid = 1'b0;
      settle();
      chk($sformatf("cont%0d_i_rsp_valid", n), 64'(i_rsp_valid), 64'(exp_i));
      chk($sformatf("cont%0d_d_rsp_valid", n), 64'(d_rsp_valid), 64'(!exp_i));
      chk($sformatf("cont%0d_rsp_data", n), exp_i ? i_rsp_data : d_rsp_data,
          64'hC0DE_0000_0000_0000 | 64'(n));
      chk($sformatf("cont%0d_resp_no_ready", n), 64'({i_req_ready, d_req_ready}), 64'd0);
      step();                                 // IDLE
      if (n == 3) begin
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
      end
    end

    // ---- backpressure: request stalled 5 cycles, response 4 cycles late
    i_req_valid = 1'b1; i_req_addr = 64'h3000; m_r_req_ready = 1'b0;
    settle();
    chk("bp_i_req_ready", 64'(i_req_ready), 64'd1);
    step();
    i_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 64'h7000;  // competitor must wait
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("bp_req%0d_valid", k), 64'(m_r_req_valid), 64'd1);
      chk($sformatf("bp_req%0d_addr", k),  m_r_req_addr,       64'h3000);
      chk($sformatf("bp_req%0d_d_ready", k), 64'(d_req_ready), 64'd0);
      step();
    end
    m_r_req_ready = 1'b1;
    step();                                   // RD_WAIT
    m_r_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("bp_wait%0d_rsp_ready", k), 64'(m_r_rsp_ready), 64'd1);
      chk($sformatf("bp_wait%0d_addr", k),      m_r_req_addr,       64'h3000);
      chk($sformatf("bp_wait%0d_i_rsp", k),     64'(i_rsp_valid),   64'd0);
      chk($sformatf("bp_wait%0d_d_ready", k),   64'(d_req_ready),   64'd0);
      step();
    end
    m_r_rsp_valid = 1'b1; m_r_rsp_data = 64'h1234;
    step();                                   // RESP
    m_r_rsp_valid = 1'b0;
    d_req_valid = 1'b0;
    settle();
    chk("bp_i_rsp_valid", 64'(i_rsp_valid), 64'd1);
    chk("bp_i_rsp_data",  i_rsp_data,       64'h1234);
    chk("bp_d_rsp_valid", 64'(d_rsp_valid), 64'd0);
    step();
    settle();
    chk("bp_single_pulse", 64'(i_rsp_valid),   64'd0);
    chk("bp_no_new_read",  64'(m_r_req_valid), 64'd0);

    // ---- reset while waiting for read data
    i_req_valid = 1'b1; i_req_addr = 64'h4000; m_r_req_ready = 1'b1;
    settle();
    chk("rw_i_req_ready", 64'(i_req_ready), 64'd1);
    step();
    i_req_valid = 1'b0;
    step();                                   // RD_WAIT
    m_r_req_ready = 1'b0;
    settle();
    chk("rw_in_wait", 64'(m_r_rsp_ready), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("rw_m_r_req_valid", 64'(m_r_req_valid), 64'd0);
    chk("rw_m_r_rsp_ready", 64'(m_r_rsp_ready), 64'd0);
    chk("rw_m_w_req_valid", 64'(m_w_req_valid), 64'd0);
    chk("rw_i_rsp_valid",   64'(i_rsp_valid),   64'd0);
    m_r_rsp_valid = 1'b1; m_r_rsp_data = 64'hFFFF;
    for (int k = 0; k < 2; k++) begin
      step();
      settle();
      chk($sformatf("rw_stray%0d_i_rsp", k), 64'(i_rsp_valid),   64'd0);
      chk($sformatf("rw_stray%0d_d_rsp", k), 64'(d_rsp_valid),   64'd0);
      chk($sformatf("rw_stray%0d_m_r",   k), 64'(m_r_req_valid), 64'd0);
    end
    m_r_rsp_valid = 1'b0;

    // ---- fetch request pulsed while busy is dropped
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h5000; m_r_req_ready = 1'b0;
    settle();
    chk("cx_d_req_ready", 64'(d_req_ready), 64'd1);
    step();                                   // RD_REQ, stalled
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 64'h6000;
    settle();
    chk("cx_i_req_ready_busy", 64'(i_req_ready), 64'd0);
    step();
    i_req_valid = 1'b0;
    m_r_req_ready = 1'b1;
    settle();
    chk("cx_m_r_req_addr", m_r_req_addr, 64'h5000);
    step();                                   // RD_WAIT
    m_r_req_ready = 1'b0;
    m_r_rsp_valid = 1'b1; m_r_rsp_data = 64'h55AA;
    step();                                   // RESP
    m_r_rsp_valid = 1'b0;
    settle();
    chk("cx_d_rsp_valid", 64'(d_rsp_valid), 64'd1);
    chk("cx_d_rsp_data",  d_rsp_data,       64'h55AA);
    chk("cx_i_rsp_valid", 64'(i_rsp_valid), 64'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("cx_idle%0d_m_r", k),   64'(m_r_req_valid), 64'd0);
      chk($sformatf("cx_idle%0d_i_rsp", k), 64'(i_rsp_valid),   64'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between two core-side requesters: instruction fetch (I, read-only) and data access (D, read or write).
- Lets the multi-cycle core run against a unified instruction/data memory.
- Accepts one request at a time, registers it, and sequences the downstream read or write handshake.
- Returns the reply to the owning requester with a one-cycle response pulse.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MASK_W, 8, byte write-mask width (DATA_W/8)

Ports:
clk  in  1  clock; all logic updates on the rising edge
rst  in  1  reset, synchronous, active-high
i_req_valid  in  1  fetch request pending
i_req_addr  in  ADDR_W  fetch address, 8-byte aligned
i_req_ready  out  1  fetch request accepted this cycle
i_rsp_valid  out  1  fetch data valid, one-cycle pulse
i_rsp_data  out  DATA_W  fetch read data
d_req_valid  in  1  data request pending
d_req_we  in  1  1 = write, 0 = read
d_req_addr  in  ADDR_W  data address
d_req_wdata  in  DATA_W  write data
d_req_wmask  in  MASK_W  byte write mask
d_req_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  data read data / write completion, one-cycle pulse
d_rsp_data  out  DATA_W  read data; 0 for a write
m_r_req_valid  out  1  downstream read request valid
m_r_req_ready  in  1  downstream read request accepted
m_r_req_addr  out  ADDR_W  downstream read address
m_r_rsp_valid  in  1  downstream read data valid
m_r_rsp_ready  out  1  arbiter ready for read data
m_r_rsp_data  in  DATA_W  downstream read data
m_w_req_valid  out  1  downstream write request valid
m_w_req_ready  in  1  downstream write request accepted
m_w_req_addr  out  ADDR_W  downstream write address
m_w_req_data  out  DATA_W  downstream write data
m_w_req_mask  out  MASK_W  downstream write mask
m_w_rsp_valid  in  1  downstream write completion
m_w_rsp_ready  out  1  arbiter ready for write completion

Behaviour:

State machine and handshake:
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE: grant at most one requester. Its req_ready is combinational, high only in IDLE for the granted requester.
  - Acceptance is req_valid && req_ready.
  - On acceptance, latch addr, we, wdata, wmask and owner into registers.
  - Next state: WR_REQ if D with we=1, else RD_REQ.
- Arbitration is round-robin with a 1-bit last_owner register, reset to D.
  - Both valid: grant the requester that is not last_owner.
  - One valid: grant it.
  - last_owner updates on each acceptance.
- RD_REQ: m_r_req_valid=1, m_r_req_addr = latched address. On m_r_req_ready, go to RD_WAIT.
- RD_WAIT: m_r_rsp_ready=1. On m_r_rsp_valid, capture m_r_rsp_data into rsp_data_q and go to RESP.
  - Reply in the same cycle as request acceptance is not possible; RD_REQ always lasts at least one cycle.
- WR_REQ: m_w_req_valid=1, with latched address, data and mask. On m_w_req_ready, go to WR_WAIT.
- WR_WAIT: m_w_rsp_ready=1. On m_w_rsp_valid, set rsp_data_q=0 and go to RESP.
- RESP: the owner's rsp_valid=1 for exactly one cycle and rsp_data = rsp_data_q; the other requester's rsp_valid=0. Next state is IDLE.
  - No new acceptance occurs in RESP.

Output rules:
- i_rsp_data and d_rsp_data both drive rsp_data_q; they are meaningful only under the matching rsp_valid.
- All downstream request fields come from registers; no combinational path from requester inputs to the m_* outputs.
- Minimum latency, acceptance to rsp_valid, with zero-wait memory: 3 cycles. The path is RD_REQ/WR_REQ (1), then RD_WAIT/WR_WAIT (1), then RESP (1).
- A requester must hold req_valid and its fields stable until req_ready. After acceptance, the inputs are ignored until RESP completes.
- Requester req_valid dropping before acceptance cancels that request with no side effect.

Reset values and reset mid-operation:
- state=IDLE, last_owner=D, all latched fields=0, rsp_data_q=0.
- All valid/ready outputs = 0, except that req_ready may rise combinationally in IDLE.
- Reset mid-transaction: return to IDLE next edge and drop all m_* valids. The downstream memory shares rst, so the outstanding transaction is abandoned and no response pulse is emitted.

Boundary cases:
- Simultaneous downstream ready/valid signals outside the current state are ignored.
- A stray m_r_rsp_valid or m_w_rsp_valid in IDLE is ignored.
- Address is passed unmodified; alignment is the requester's responsibility.

Decomposition:
- Package MemArbPack holds:
  - arb_state_e {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP}
  - owner_e {OWN_I, OWN_D}
  - widths via CorePack addr_t/data_t/mask_t
- One sub-module, rr_pick2: the combinational 2-way round-robin grant from (i_valid, d_valid, last_owner). The FSM, registers and response logic stay in mem_port_arbiter.

Test Plan:
- Lone fetch: i_req_valid, addr 0x1000; memory ready immediately, replies 0xDEADBEEF_00000013 the next cycle -> i_req_ready in cycle 0, i_rsp_valid pulse in cycle 3 with that data; d_rsp_valid stays 0.
- Data write: d_req_we=1, addr 0x2008, wdata 0x55, mask 0x01 -> m_w_req_* carry exactly those values; d_rsp_valid pulses with d_rsp_data=0; no m_r_req_valid activity.
- Contention: I and D both valid continuously after reset -> grants alternate I, D, I, D (last_owner reset = D); each response is routed only to its owner.
- Backpressure: hold m_r_req_ready=0 for 5 cycles, then m_r_rsp_valid delayed 4 cycles -> m_r_req_addr stays stable throughout; exactly one rsp pulse; no second acceptance meanwhile.
- Reset in RD_WAIT: assert rst for 1 cycle -> next cycle state IDLE, all m_* valids 0, no rsp pulse; a later m_r_rsp_valid is ignored.
- Cancel: i_req_valid high one cycle while the arbiter is busy, then low -> never accepted, no downstream read issued for it.
